// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - sequences word loading, round strobes and block chaining for a SHA-256 core
module sha256_block_sequencer #(
    parameter int WORDS  = 16,
    parameter int ROUNDS = 64,
    parameter int BLK_W  = 8,
    parameter int HASH_W = 256,
    parameter int RND_W  = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [BLK_W-1:0]         num_blocks,
    input  logic                     abort,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [31:0]              sched_wr_data,
    output logic [$clog2(WORDS)-1:0] sched_wr_addr,
    output logic                     sched_wr_en,
    output logic                     sched_start,
    output logic [RND_W-1:0]         sched_round,
    output logic                     sched_stn,
    input  logic [31:0]              sched_wt,
    output logic [31:0]              comp_wt,
    output logic                     comp_start,
    output logic                     comp_first_block,
    input  logic                     comp_stn,
    input  logic                     comp_done,
    input  logic [HASH_W-1:0]        comp_hash,
    output logic [HASH_W-1:0]        hash_out,
    output logic                     done,
    output logic                     busy,
    output logic [BLK_W-1:0]         block_idx,
    output logic                     err
);
    localparam int ADDR_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [RND_W-1:0]  LAST_RND  = RND_W'(ROUNDS - 1);
    localparam logic [RND_W-1:0]  MAX_RND   = RND_W'(ROUNDS);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, WAIT_DONE} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] load_cnt;
    logic [RND_W-1:0]  round_cnt;
    logic [BLK_W-1:0]  nblk;
    logic              start_pulse;

    logic accept, last_word, msg_go, round_step, blk_next, msg_done, early_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decoded actions are qualified by abort in the datapath so abort wins over every one of them.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        last_word  = 1'b0;
        msg_go     = 1'b0;
        round_step = 1'b0;
        blk_next   = 1'b0;
        msg_done   = 1'b0;
        early_done = 1'b0;
        case (state)
            IDLE: begin
                if (start && num_blocks != '0) begin
                    msg_go     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready   = 1'b1;
                accept     = in_valid;
                early_done = comp_done;
                if (in_valid && load_cnt == LAST_WORD) begin
                    last_word  = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                early_done = comp_done;
                round_step = comp_stn && (round_cnt != MAX_RND);
                if (comp_stn && round_cnt == LAST_RND) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (comp_done) begin
                    if (block_idx < nblk - 1'b1) begin
                        blk_next   = 1'b1;
                        state_next = LOAD;
                    end else begin
                        msg_done   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    assign sched_wr_en   = accept;
    assign sched_wr_data = accept ? in_data : 32'd0;
    assign sched_wr_addr = accept ? load_cnt : '0;
    assign sched_stn     = comp_stn;
    assign sched_round   = round_cnt;
    assign sched_start   = start_pulse;
    assign comp_start    = start_pulse;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt         <= '0;
            round_cnt        <= '0;
            nblk             <= '0;
            block_idx        <= '0;
            comp_first_block <= 1'b0;
            start_pulse      <= 1'b0;
            comp_wt          <= 32'd0;
            hash_out         <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            done        <= 1'b0;
            if (state == ROUND) begin
                comp_wt <= sched_wt;
            end
            if (!abort) begin
                if (msg_go) begin
                    nblk             <= num_blocks;
                    block_idx        <= '0;
                    comp_first_block <= 1'b1;
                    load_cnt         <= '0;
                    err              <= 1'b0;
                end
                if (early_done) begin
                    err <= 1'b1;
                end
                if (accept) begin
                    load_cnt <= last_word ? '0 : load_cnt + 1'b1;
                end
                if (last_word) begin
                    round_cnt   <= '0;
                    start_pulse <= 1'b1;
                end
                if (round_step) begin
                    round_cnt <= round_cnt + 1'b1;
                end
                if (blk_next) begin
                    block_idx        <= block_idx + 1'b1;
                    comp_first_block <= 1'b0;
                    load_cnt         <= '0;
                end
                if (msg_done) begin
                    hash_out <= comp_hash;
                    done     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb/tb_sha256_block_sequencer.sv - randomized and directed bench with a message-level reference model
module tb_sha256_block_sequencer;
    localparam int WORDS  = 16;
    localparam int ROUNDS = 64;
    localparam int BLK_W  = 8;
    localparam int HASH_W = 256;
    localparam int RND_W  = 7;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [BLK_W-1:0]  num_blocks = '0;
    logic              abort = 1'b0;
    logic [31:0]       in_data = 32'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       sched_wr_data;
    logic [3:0]        sched_wr_addr;
    logic              sched_wr_en;
    logic              sched_start;
    logic [RND_W-1:0]  sched_round;
    logic              sched_stn;
    logic [31:0]       sched_wt = 32'd0;
    logic [31:0]       comp_wt;
    logic              comp_start;
    logic              comp_first_block;
    logic              comp_stn = 1'b0;
    logic              comp_done = 1'b0;
    logic [HASH_W-1:0] comp_hash = '0;
    logic [HASH_W-1:0] hash_out;
    logic              done;
    logic              busy;
    logic [BLK_W-1:0]  block_idx;
    logic              err;

    sha256_block_sequencer #(
        .WORDS(WORDS), .ROUNDS(ROUNDS), .BLK_W(BLK_W), .HASH_W(HASH_W), .RND_W(RND_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_blocks(num_blocks), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sched_wr_data(sched_wr_data), .sched_wr_addr(sched_wr_addr), .sched_wr_en(sched_wr_en),
        .sched_start(sched_start), .sched_round(sched_round), .sched_stn(sched_stn), .sched_wt(sched_wt),
        .comp_wt(comp_wt), .comp_start(comp_start), .comp_first_block(comp_first_block),
        .comp_stn(comp_stn), .comp_done(comp_done), .comp_hash(comp_hash),
        .hash_out(hash_out), .done(done), .busy(busy), .block_idx(block_idx), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting words, 2 counting rounds, 3 awaiting the core.
    int           m_phase = 0;
    int           m_words = 0;
    int           m_rounds = 0;
    int           m_blocks = 0;
    int           m_blk = 0;
    bit           m_first = 0;
    bit           m_done = 0;
    bit           m_err = 0;
    bit           m_pulse = 0;
    logic [255:0] m_hash = '0;
    logic [31:0]  m_wt = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_words = 0; m_rounds = 0; m_blocks = 0; m_blk = 0;
            m_first = 0; m_done = 0; m_err = 0; m_pulse = 0; m_hash = '0; m_wt = 32'd0;
        end else begin
            m_done  = 0;
            m_pulse = 0;
            if (m_phase == 2) m_wt = sched_wt;
            if (abort) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (start && num_blocks != 0) begin
                    m_blocks = int'(num_blocks); m_blk = 0; m_first = 1; m_words = 0; m_err = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (comp_done) m_err = 1;
                if (in_valid) begin
                    m_words++;
                    if (m_words == WORDS) begin
                        m_phase = 2; m_rounds = 0; m_pulse = 1;
                    end
                end
            end else if (m_phase == 2) begin
                if (comp_done) m_err = 1;
                if (comp_stn) begin
                    m_rounds++;
                    if (m_rounds == ROUNDS) m_phase = 3;
                end
            end else begin
                if (comp_done) begin
                    if (m_blk + 1 < m_blocks) begin
                        m_blk++; m_first = 0; m_words = 0; m_phase = 1;
                    end else begin
                        m_hash = comp_hash; m_done = 1; m_phase = 0;
                    end
                end
            end
        end
    end

    logic check_en = 1'b0;
    int   wr_count = 0;
    int   done_count = 0;
    int   addr_log[$];
    int   blk_log[$];
    int   first_log[$];

    always @(negedge clk) begin
        logic exp_acc;
        if (check_en) begin
            exp_acc = (m_phase == 1) && in_valid;
            chk("in_ready", in_ready, m_phase == 1);
            chk("sched_wr_en", sched_wr_en, exp_acc);
            chk("sched_wr_addr", sched_wr_addr, exp_acc ? m_words : 0);
            chk("sched_wr_data", sched_wr_data, exp_acc ? in_data : 32'd0);
            chk("sched_stn", sched_stn, comp_stn);
            chk("sched_round", sched_round, m_rounds);
            chk("sched_start", sched_start, m_pulse);
            chk("comp_start", comp_start, m_pulse);
            chk("comp_wt", comp_wt, m_wt);
            chk("comp_first_block", comp_first_block, m_first);
            chk("hash_out", hash_out, m_hash);
            chk("done", done, m_done);
            chk("busy", busy, m_phase != 0);
            chk("block_idx", block_idx, m_blk);
            chk("err", err, m_err);
            if (sched_wr_en) begin
                wr_count++;
                addr_log.push_back(int'(sched_wr_addr));
            end
            if (done) done_count++;
            if (comp_start) begin
                blk_log.push_back(int'(block_idx));
                first_log.push_back(int'(comp_first_block));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        sched_wt = $urandom;
    endtask

    task automatic begin_msg(input int n);
        start = 1'b1;
        num_blocks = BLK_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic feed_n(input int n, input int pct);
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < n && guard < 400) begin
            in_valid = ($urandom_range(99) < pct);
            in_data = $urandom;
            step();
            if (in_valid) got++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 400) chk("feed_bound", got, n);
    endtask

    task automatic feed(input int pct);
        feed_n(WORDS, pct);
    endtask

    task automatic rounds(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap)) step();
            comp_stn = 1'b1;
            step();
            comp_stn = 1'b0;
        end
    endtask

    task automatic finish_blk(input logic [255:0] h);
        comp_hash = h;
        comp_done = 1'b1;
        step();
        comp_done = 1'b0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h1, h2, h3, h4, h5;
        int s_wr, s_done, s_log, s_addr, nb, ab;
        h1 = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
        h2 = 256'hdeadbeef_cafef00d_12345678_9abcdef0_0badc0de_feedface_01020304_05060708;
        h3 = 256'h1;
        h4 = 256'hffffffff_00000000_a5a5a5a5_5a5a5a5a_ffffffff_00000000_a5a5a5a5_5a5a5a5a;
        h5 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_hash", hash_out, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_block_idx", block_idx, 0);
        chk("rst_round", sched_round, 0);
        chk("rst_comp_start", comp_start, 0);
        chk("rst_first", comp_first_block, 0);
        reset_n = 1'b1;
        check_en = 1'b1;
        step();

        // single block, back-to-back words
        s_wr = wr_count; s_done = done_count; s_log = blk_log.size();
        begin_msg(1);
        feed(100);
        rounds(64, 0);
        finish_blk(h1);
        chk("single_done_pulse", done, 1);
        step();
        chk("single_done_once", done, 0);
        chk("single_done_cnt", done_count - s_done, 1);
        chk("single_hash", hash_out, h1);
        chk("single_wr_cnt", wr_count - s_wr, 16);
        chk("single_first", first_log[s_log], 1);

        // three blocks with throttled input
        s_wr = wr_count; s_done = done_count; s_log = blk_log.size(); s_addr = addr_log.size();
        begin_msg(3);
        for (int b = 0; b < 3; b++) begin
            feed(50);
            rounds(64, 1);
            finish_blk(b == 2 ? h2 : rand256());
        end
        step();
        chk("multi_wr_cnt", wr_count - s_wr, 48);
        for (int i = 0; i < 48; i++) chk("multi_addr", addr_log[s_addr + i], i % 16);
        for (int k = 0; k < 3; k++) begin
            chk("multi_blk_seq", blk_log[s_log + k], k);
            chk("multi_first_seq", first_log[s_log + k], k == 0);
        end
        chk("multi_done_cnt", done_count - s_done, 1);
        chk("multi_hash", hash_out, h2);

        // boundaries
        start = 1'b1; num_blocks = '0;
        step();
        start = 1'b0;
        chk("zero_blocks_busy", busy, 0);
        step();
        chk("zero_blocks_busy2", busy, 0);
        begin_msg(1);
        start = 1'b1; num_blocks = 8'd5;
        step();
        start = 1'b0;
        chk("busy_start_blk", block_idx, 0);
        feed(100);
        rounds(64, 0);
        chk("round_at_max", sched_round, 64);
        rounds(6, 0);
        chk("round_saturated", sched_round, 64);
        finish_blk(h3);
        chk("busy_start_done", done, 1);
        chk("busy_start_hash", hash_out, h3);
        step();

        // error handling and abort
        begin_msg(1);
        feed_n(3, 100);
        comp_done = 1'b1;
        step();
        comp_done = 1'b0;
        chk("err_set", err, 1);
        chk("err_stays_load", in_ready, 1);
        feed_n(13, 100);
        rounds(64, 0);
        finish_blk(h4);
        step();
        chk("err_sticky", err, 1);
        chk("err_msg_hash", hash_out, h4);
        begin_msg(1);
        chk("err_cleared", err, 0);
        feed(100);
        rounds(64, 0);
        s_done = done_count;
        comp_hash = rand256();
        comp_done = 1'b1;
        abort = 1'b1;
        step();
        comp_done = 1'b0;
        abort = 1'b0;
        chk("abort_no_done", done, 0);
        chk("abort_hash_kept", hash_out, h4);
        chk("abort_idle", busy, 0);
        step();
        chk("abort_done_cnt", done_count - s_done, 0);

        // reset during the second block's rounds
        begin_msg(3);
        feed(100);
        rounds(64, 0);
        finish_blk(rand256());
        feed(100);
        rounds(10, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hash", hash_out, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_block_idx", block_idx, 0);
        chk("mid_rst_comp_wt", comp_wt, 0);
        chk("mid_rst_comp_start", comp_start, 0);
        chk("mid_rst_sched_start", sched_start, 0);
        chk("mid_rst_first", comp_first_block, 0);
        chk("mid_rst_round", sched_round, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        step();
        reset_n = 1'b1;
        step();
        begin_msg(1);
        feed(70);
        rounds(64, 2);
        finish_blk(h5);
        chk("post_rst_done", done, 1);
        chk("post_rst_hash", hash_out, h5);
        step();

        // randomized messages
        for (int m = 0; m < 25; m++) begin
            nb = $urandom_range(4, 1);
            ab = $urandom_range(9);
            begin_msg(nb);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(7) == 0) begin
                    comp_done = 1'b1;
                    step();
                    comp_done = 1'b0;
                end
                feed($urandom_range(100, 30));
                if (ab == 0 && b == nb - 1) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    break;
                end
                rounds(64, 2);
                if ($urandom_range(3) == 0) rounds(2, 0);
                finish_blk(rand256());
            end
            repeat (2) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha256_block_sequencer.md
SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL take parameters (name, default, meaning): WORDS, 16, message words loaded per block; ROUNDS, 64, compression rounds per block; BLK_W, 8, width of block count; HASH_W, 256, digest width; RND_W, 7, round counter width, equal to clog2(ROUNDS+1).
REQ-002 SHALL have these ports (name, direction, width, meaning): clk, in, 1, single clock; reset_n, in, 1, asynchronous active-low reset.
REQ-003 start, in, 1, request a new message; num_blocks, in, BLK_W, blocks in the message, sampled with start; abort, in, 1, synchronous cancel.
REQ-004 in_data, in, 32, message word; in_valid, in, 1, word present; in_ready, out, 1, word accepted when in_valid and in_ready are both 1.
REQ-005 sched_wr_data, out, 32; sched_wr_addr, out, clog2(WORDS); sched_wr_en, out, 1; sched_start, out, 1; sched_round, out, RND_W; sched_stn, out, 1; sched_wt, in, 32.
REQ-006 comp_wt, out, 32; comp_start, out, 1; comp_first_block, out, 1; comp_stn, in, 1; comp_done, in, 1; comp_hash, in, HASH_W.
REQ-007 hash_out, out, HASH_W; done, out, 1; busy, out, 1; block_idx, out, BLK_W; err, out, 1.

Function
REQ-008 SHALL use one FSM with states IDLE, LOAD, ROUND, WAIT_DONE; all registers SHALL be clocked on clk only, so no signal is used as a clock.
REQ-009 In IDLE, start=1 with num_blocks!=0 SHALL, on the next edge: latch num_blocks; set block_idx=0, comp_first_block=1, load counter=0; clear err; enter LOAD.
REQ-010 start with num_blocks=0 SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-011 LOAD: in_ready SHALL be 1.
REQ-012 LOAD: sched_wr_en=in_valid&in_ready, sched_wr_data=in_data, sched_wr_addr=load counter, all combinational; otherwise all three SHALL be 0.
REQ-013 Each accepted word SHALL increment the load counter.
REQ-014 Acceptance of word WORDS-1 SHALL, on the next edge: enter ROUND, clear the round counter to 0, and pulse sched_start and comp_start high for exactly 1 cycle.
REQ-015 comp_stn SHALL be treated as a 1-cycle synchronous strobe; sched_stn SHALL equal comp_stn combinationally.
REQ-016 In ROUND, each cycle with comp_stn=1 SHALL increment the round counter; sched_round SHALL equal the round counter.
REQ-017 In ROUND, comp_wt SHALL be registered from sched_wt every cycle, giving 1-cycle latency.
REQ-018 The strobe that brings the round counter to ROUNDS SHALL move the FSM to WAIT_DONE; the round counter SHALL saturate at ROUNDS, and strobes outside ROUND SHALL be ignored.
REQ-019 WAIT_DONE, comp_done=1, block_idx<num_blocks-1: SHALL increment block_idx, clear comp_first_block, clear the load counter and return to LOAD.
REQ-020 WAIT_DONE, comp_done=1, block_idx==num_blocks-1: SHALL register hash_out from comp_hash, pulse done for 1 cycle and return to IDLE.
REQ-021 hash_out SHALL hold its value until the next final block completes.
REQ-022 comp_done=1 in LOAD or ROUND SHALL set err (sticky) and otherwise be ignored.
REQ-023 abort=1 SHALL return the FSM to IDLE from any state on the next edge; no done pulse, hash_out unchanged; abort SHALL take priority over start, comp_done and in_valid in the same cycle.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 block_idx, the round counter and the load counter SHALL wrap nowhere: all are bounded by num_blocks-1, ROUNDS and WORDS-1 respectively.

Reset
REQ-026 reset_n=0 SHALL asynchronously force IDLE and zero every register output: hash_out, done, err, block_idx, comp_wt, comp_start, sched_start, comp_first_block, and all counters.
REQ-027 Reset asserted mid-message SHALL discard the message; after release the block SHALL accept a new start normally.

Verification
REQ-028 Single block: start with num_blocks=1, 16 words back-to-back, 64 stn strobes, then comp_done with comp_hash=H -> done pulses once, hash_out=H, comp_first_block stays 1 throughout.
REQ-029 Three blocks with in_valid toggled 50%: exactly 48 sched_wr_en pulses with addresses 0..15 three times; block_idx steps 0,1,2; comp_first_block=0 from block 1; exactly one done pulse.
REQ-030 Boundaries: start with num_blocks=0 -> busy stays 0; start while busy -> no effect; stn strobes 65..70 -> sched_round stays 64.
REQ-031 Errors: comp_done during LOAD -> err=1 and the FSM stays in LOAD; the next accepted start clears err; abort in the same cycle as comp_done in WAIT_DONE -> IDLE, done=0, hash_out unchanged.
REQ-032 Reset: reset_n pulsed low during ROUND of block 2 -> all outputs 0 immediately; a following 1-block message completes correctly.
